// File: rtl/hycontrol_response_tx.sv
// hycontrol_response_tx: buffers an HY response packet (1-32 bytes) and streams it
// out in address order on a byte-wide AXI4-Stream master, tlast on the final byte.
module hycontrol_response_tx #(
    parameter int BUF_AW = 5,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BUF_AW-1:0] addr,
    input  logic [DW-1:0]     dat_i,
    input  logic              write,
    input  logic [BUF_AW-1:0] len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;
    state_t            state;
    logic [DW-1:0]     mem [2**BUF_AW];
    logic [BUF_AW-1:0] last_idx, rd_ptr;
    logic [DW-1:0]     rd_data, skid_data;
    logic              rd_v, rd_last, rd_end, skid_v, skid_last, fire, rd_en;
    logic [1:0]        occ;
    assign fire = m_axis_tvalid && m_axis_tready;
    // bytes held or in flight after this cycle's handshake; a read needs a free slot
    always_comb occ = 2'(m_axis_tvalid) + 2'(skid_v) + 2'(rd_v) - 2'(fire);
    assign rd_en = (state == PRIME) || (state == STREAM && !rd_end && occ < 2'd2);
    always_ff @(posedge clk) begin
        if (write && !busy) mem[addr] <= dat_i;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            last_idx      <= '0;
            rd_ptr        <= '0;
            rd_data       <= '0;
            rd_v          <= 1'b0;
            rd_last       <= 1'b0;
            rd_end        <= 1'b0;
            skid_v        <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
        end else begin
            rd_v <= rd_en;
            done <= 1'b0;
            if (rd_en) begin
                rd_data <= mem[rd_ptr];
                rd_last <= rd_ptr == last_idx;
                if (rd_ptr == last_idx) rd_end <= 1'b1;
                else rd_ptr <= rd_ptr + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    last_idx <= len;
                    rd_ptr   <= '0;
                    rd_end   <= 1'b0;
                    busy     <= 1'b1;
                    state    <= PRIME;
                end
                PRIME: state <= STREAM;
                STREAM: begin
                    if (fire && m_axis_tlast) begin
                        state         <= DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        skid_v        <= 1'b0;
                    end else if (fire || !m_axis_tvalid) begin
                        if (skid_v) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= skid_data;
                            m_axis_tlast  <= skid_last;
                            skid_v        <= rd_v;
                            skid_data     <= rd_data;
                            skid_last     <= rd_last;
                        end else begin
                            m_axis_tvalid <= rd_v;
                            m_axis_tdata  <= rd_data;
                            m_axis_tlast  <= rd_v && rd_last;
                        end
                    end else if (rd_v) begin
                        skid_v    <= 1'b1;
                        skid_data <= rd_data;
                        skid_last <= rd_last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hycontrol_response_tx.sv
// tb_hycontrol_response_tx: randomized scoreboard bench for the HY response transmitter.
module tb_hycontrol_response_tx;
    typedef struct packed {logic [7:0] d; logic l;} beat_t;
    logic       clk, rst_n, write, start, tready;
    logic [4:0] addr, len;
    logic [7:0] dat_i, tdata;
    logic       busy, done, tvalid, tlast;
    int         checks = 0, errors = 0, cyc = 0;
    int         pct = 100, fv_cyc = -1, last_fire_cyc = -1, fire_cnt = 0, done_cnt = 0;
    int         hold_mode = 0, hold_cnt = 0, seen_last = 0;
    logic [7:0] mb [32];
    beat_t      q [$];
    logic       prev_stall = 0, pl;
    logic [7:0] pd;

    hycontrol_response_tx #(.BUF_AW(5), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .dat_i(dat_i), .write(write),
        .len(len), .start(start), .busy(busy), .done(done),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        tready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_mode != 0 && tvalid && tlast && hold_cnt < 10) begin
                tready = 0;
                hold_cnt++;
            end else tready = (pct >= 100) || ($urandom_range(99) < pct);
        end
    end

    // monitor: pops the scoreboard on every handshake and checks stall stability
    always @(negedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, tvalid}, 1);
                chk("stall_data", {24'd0, tdata}, {24'd0, pd});
                chk("stall_last", {31'd0, tlast}, {31'd0, pl});
            end
            if (tvalid && fv_cyc < 0) fv_cyc = cyc;
            if (tvalid && tready) begin
                fire_cnt++;
                if (tlast) begin
                    last_fire_cyc = cyc;
                    seen_last = 1;
                end
                if (q.size() == 0) chk("extra_beat", {23'd0, tdata, tlast}, 32'hFFFF);
                else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat", {23'd0, tdata, tlast}, {23'd0, e.d, e.l});
                end
            end
            if (done) done_cnt++;
            prev_stall = tvalid && !tready;
            pd = tdata;
            pl = tlast;
        end
    end

    task automatic wr(input int a, input logic [7:0] d);
        @(posedge clk);
        #1;
        write = 1;
        addr = 5'(a);
        dat_i = d;
        @(posedge clk);
        #1;
        write = 0;
        mb[a] = d;
    endtask

    task automatic run_pkt(input int l, input int p);
        int n, t, dc;
        pct = p;
        fv_cyc = -1;
        dc = done_cnt;
        for (int i = 0; i <= l; i++) q.push_back({mb[i], i == l});
        @(posedge clk);
        #1;
        start = 1;
        len = 5'(l);
        n = cyc + 1;
        @(posedge clk);
        #1;
        start = 0;
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 1);
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {31'd0, done}, 1);
        chk("busy_at_done", {31'd0, busy}, 0);
        chk("done_after_last", cyc, last_fire_cyc + 1);
        chk("scoreboard_drained", q.size(), 0);
        if (p == 100 && hold_mode == 0) begin
            chk("first_valid_cyc", fv_cyc, n + 2);
            chk("done_cyc", cyc, n + 3 + l);
        end
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("done_count", done_cnt, dc + 1);
        chk("valid_after_done", {31'd0, tvalid}, 0);
    endtask

    initial begin
        int t;
        rst_n = 0;
        write = 0;
        start = 0;
        addr = 0;
        len = 0;
        dat_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_valid", {31'd0, tvalid}, 0);
        chk("rst_last", {31'd0, tlast}, 0);
        chk("rst_data", {24'd0, tdata}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int i = 0; i < 4; i++) wr(i, 8'hA0 + 8'(i));
        run_pkt(3, 100);
        wr(0, 8'h5A);
        run_pkt(0, 100);

        for (int i = 0; i < 32; i++) wr(i, 8'(i));
        run_pkt(31, 50);

        // writes and a start while busy must leave no trace
        fork
            run_pkt(7, 100);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("busy_during_write", {31'd0, busy}, 1);
                write = 1;
                addr = 2;
                dat_i = 8'hFF;
                start = 1;
                @(posedge clk);
                #1;
                write = 0;
                start = 0;
            end
        join
        run_pkt(7, 100);

        // reset after two bytes of an eight-byte packet
        fire_cnt = 0;
        seen_last = 0;
        pct = 100;
        for (int i = 0; i < 8; i++) q.push_back({mb[i], i == 7});
        @(posedge clk);
        #1;
        start = 1;
        len = 7;
        @(posedge clk);
        #1;
        start = 0;
        t = 0;
        while (fire_cnt < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("reset_wait", {31'd0, t < 500}, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", {31'd0, tvalid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_no_last", seen_last, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        run_pkt(7, 100);

        hold_mode = 1;
        hold_cnt = 0;
        run_pkt(4, 100);
        chk("hold_cycles", hold_cnt, 10);
        hold_mode = 0;

        for (int k = 0; k < 8; k++) begin
            int l, p;
            l = $urandom_range(31);
            p = (k % 3 == 0) ? 100 : $urandom_range(90, 20);
            for (int i = 0; i <= l; i++) if ($urandom_range(1) == 1) wr(i, 8'($urandom));
            run_pkt(l, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
